// File: rtl/udp_pkg.sv
// udp_pkg: shared types and constants for the UDP receive parser.
package udp_pkg;
    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} udp_rx_state_t;
    localparam int UDP_HDR_BYTES = 8;
    localparam int SRC_OFF = 0;
    localparam int DST_OFF = 2;
    localparam int LEN_OFF = 4;
    localparam int CSUM_OFF = 6;
    // Extract a big-endian 16-bit field at byte offset off of the 8-byte header.
    function automatic logic [15:0] hdr_field(input logic [63:0] h, input int off);
        return 16'(h >> (8 * (6 - off)));
    endfunction
endpackage

// File: rtl/udp_rx_parser_if.sv
// udp_rx_parser_if: upstream FIFO read port and downstream FIFO write port.
interface udp_rx_parser_if;
    logic       in_rd_en;
    logic [7:0] in_dout;
    logic       in_sof;
    logic       in_eof;
    logic       in_empty;
    logic       out_wr_en;
    logic [7:0] out_din;
    logic       out_sof;
    logic       out_eof;
    logic       out_full;
    modport master (
        output in_rd_en, out_wr_en, out_din, out_sof, out_eof,
        input  in_dout, in_sof, in_eof, in_empty, out_full
    );
    modport slave (
        input  in_rd_en, out_wr_en, out_din, out_sof, out_eof,
        output in_dout, in_sof, in_eof, in_empty, out_full
    );
endinterface

// File: rtl/udp_rx_parser_byte_skid.sv
// byte_skid: one-entry holding register for {sof, eof, byte} with valid flag.
module byte_skid (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       clear,
    input  logic [9:0] d,
    output logic       valid,
    output logic [9:0] q
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/udp_rx_parser.sv
// udp_rx_parser: parses UDP headers from a framed byte FIFO and forwards
// payload of packets addressed to cfg_port, with error pulses and counters.
module udp_rx_parser #(
    parameter int UDP_HDR_BYTES = 8,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    udp_rx_parser_if.master      bus,
    input  logic [15:0]          cfg_port,
    output logic                 hdr_valid,
    output logic [15:0]          src_port,
    output logic [15:0]          dst_port,
    output logic [15:0]          udp_len,
    output logic [15:0]          udp_csum,
    output logic                 err_short,
    output logic                 err_len,
    output logic                 err_framing,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic [CNT_WIDTH-1:0] drop_count
);
    import udp_pkg::*;

    udp_rx_state_t state, state_n;
    logic        rd_pend, skid_valid, v, b_sof, b_eof;
    logic [9:0]  skid_q, in_word;
    logic [7:0]  b;
    logic [15:0] byte_cnt, byte_cnt_n, hdr_len;
    logic [55:0] hdr_sr, hdr_sr_n;
    logic [63:0] hdr_word;
    logic        port_ok, port_ok_n, first, first_n;
    logic        wr_n, osof_n, oeof_n, hv_n, es_n, el_n, ef_n, pkt_inc, drop_inc;

    assign bus.in_rd_en = !bus.in_empty && !bus.out_full && !skid_valid;
    assign in_word = {bus.in_sof, bus.in_eof, bus.in_dout};
    // Skid and a fresh return never coexist: the skid only loads while full blocks new pops.
    assign {b_sof, b_eof, b} = skid_valid ? skid_q : in_word;
    assign v = (skid_valid || rd_pend) && !bus.out_full;
    assign hdr_word = {hdr_sr, b};
    assign hdr_len = hdr_field(hdr_word, LEN_OFF);

    byte_skid u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (rd_pend && bus.out_full),
        .clear (skid_valid && !bus.out_full),
        .d     (in_word),
        .valid (skid_valid),
        .q     (skid_q)
    );

    always_comb begin
        state_n    = state;
        byte_cnt_n = byte_cnt;
        hdr_sr_n   = hdr_sr;
        port_ok_n  = port_ok;
        first_n    = first;
        wr_n       = 1'b0;
        osof_n     = 1'b0;
        oeof_n     = 1'b0;
        hv_n       = 1'b0;
        es_n       = 1'b0;
        el_n       = 1'b0;
        ef_n       = 1'b0;
        pkt_inc    = 1'b0;
        drop_inc   = 1'b0;
        if (v && b_sof) begin
            ef_n       = state != IDLE;
            es_n       = b_eof;
            hdr_sr_n   = {48'd0, b};
            byte_cnt_n = 16'd1;
            state_n    = b_eof ? IDLE : HDR;
        end else if (v) begin
            case (state)
                HDR: begin
                    hdr_sr_n   = {hdr_sr[47:0], b};
                    byte_cnt_n = byte_cnt + 16'd1;
                    if (byte_cnt == 16'(DST_OFF + 1))
                        port_ok_n = {hdr_sr[7:0], b} == cfg_port;
                    if (byte_cnt == 16'(UDP_HDR_BYTES - 1)) begin
                        hv_n     = 1'b1;
                        pkt_inc  = 1'b1;
                        first_n  = 1'b1;
                        drop_inc = !(port_ok && hdr_len >= 16'(UDP_HDR_BYTES));
                        el_n     = b_eof ? hdr_len != 16'(UDP_HDR_BYTES) : hdr_len < 16'(UDP_HDR_BYTES);
                        state_n  = b_eof ? IDLE : (drop_inc ? DROP : PAYLOAD);
                    end else if (b_eof) begin
                        es_n    = 1'b1;
                        state_n = IDLE;
                    end
                end
                PAYLOAD: begin
                    wr_n       = 1'b1;
                    osof_n     = first;
                    oeof_n     = b_eof;
                    first_n    = 1'b0;
                    byte_cnt_n = byte_cnt + 16'd1;
                    el_n       = b_eof && byte_cnt_n != udp_len;
                    state_n    = b_eof ? IDLE : PAYLOAD;
                end
                DROP: state_n = b_eof ? IDLE : DROP;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            rd_pend       <= 1'b0;
            byte_cnt      <= '0;
            hdr_sr        <= '0;
            port_ok       <= 1'b0;
            first         <= 1'b0;
            bus.out_wr_en <= 1'b0;
            bus.out_sof   <= 1'b0;
            bus.out_eof   <= 1'b0;
            bus.out_din   <= '0;
            hdr_valid     <= 1'b0;
            err_short     <= 1'b0;
            err_len       <= 1'b0;
            err_framing   <= 1'b0;
            src_port      <= '0;
            dst_port      <= '0;
            udp_len       <= '0;
            udp_csum      <= '0;
            pkt_count     <= '0;
            drop_count    <= '0;
        end else begin
            state         <= state_n;
            rd_pend       <= bus.in_rd_en;
            byte_cnt      <= byte_cnt_n;
            hdr_sr        <= hdr_sr_n;
            port_ok       <= port_ok_n;
            first         <= first_n;
            bus.out_wr_en <= wr_n;
            bus.out_sof   <= osof_n;
            bus.out_eof   <= oeof_n;
            if (wr_n) bus.out_din <= b;
            hdr_valid     <= hv_n;
            err_short     <= es_n;
            err_len       <= el_n;
            err_framing   <= ef_n;
            if (hv_n) begin
                src_port <= hdr_field(hdr_word, SRC_OFF);
                dst_port <= hdr_field(hdr_word, DST_OFF);
                udp_len  <= hdr_len;
                udp_csum <= hdr_field(hdr_word, CSUM_OFF);
            end
            pkt_count  <= pkt_count + CNT_WIDTH'(pkt_inc);
            drop_count <= drop_count + CNT_WIDTH'(drop_inc);
        end
    end
endmodule
